// File: rtl/div23_recon_pkg.sv
// rtl/div23_recon_pkg.sv - shared constants and state type for the div23 reconstructor
// Purpose: default geometry (WIDTH, DIGIT, DIVISOR), derived carry width CW and
//          digit count NDIG, and the three-state FSM encoding.
// Ports:   none (package).
package div23_recon_pkg;

    localparam int WIDTH_DEF   = 64;
    localparam int DIGIT_DEF   = 4;
    localparam int DIVISOR_DEF = 23;
    localparam int CW          = $clog2(DIVISOR_DEF);
    localparam int NDIG        = WIDTH_DEF / DIGIT_DEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div23_digit_mac.sv
// rtl/div23_digit_mac.sv - combinational digit x constant plus carry
// Purpose: p = digit*DIVISOR + carry_in; returns the low DIGIT bits of p and
//          the next carry p >> DIGIT.
// Ports:   digit     - DIGIT-bit quotient digit
//          carry_in  - CW-bit incoming carry
//          sum       - low DIGIT bits of the product-sum
//          carry_out - upper CW bits of the product-sum
module div23_digit_mac #(
    parameter int DIGIT   = 4,
    parameter int DIVISOR = 23,
    parameter int CW      = 5
) (
    input  logic [DIGIT-1:0] digit,
    input  logic [CW-1:0]    carry_in,
    output logic [DIGIT-1:0] sum,
    output logic [CW-1:0]    carry_out
);

    // With carry_in < 2^CW and digit < 2^DIGIT the sum stays below
    // 2^(DIGIT+CW) for DIVISOR < 2^CW, so no bits are lost.
    localparam int PW = DIGIT + CW;

    logic [PW-1:0] p;

    assign p         = PW'(digit) * PW'(DIVISOR) + PW'(carry_in);
    assign sum       = p[DIGIT-1:0];
    assign carry_out = p[PW-1:DIGIT];

endmodule

// File: rtl/div23_recon.sv
// rtl/div23_recon.sv - digit-serial rebuild of x = q*DIVISOR + r, LSB digit first
// Purpose: accepts a quotient/remainder pair, multiplies one DIGIT-bit digit of
//          the quotient per cycle by DIVISOR, and presents the WIDTH-bit
//          dividend plus an overflow flag.
// Option:  DIV23_RECON_RANGE_CHECK_EN - when defined, err latches (r_in >= DIVISOR)
//          at acceptance; otherwise err is constant 0.
// Ports:   clk, rst        - clock (rising edge), async active-high reset
//          in_valid/in_ready, q_in, r_in   - input pair handshake
//          out_valid/out_ready, x_out, ovf, err - result handshake
module div23_recon
    import div23_recon_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int DIGIT   = DIGIT_DEF,
    parameter int DIVISOR = DIVISOR_DEF,
    localparam int RW     = $clog2(DIVISOR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] q_in,
    input  logic [RW-1:0]    r_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x_out,
    output logic             ovf,
    output logic             err
);

    localparam int ND   = WIDTH / DIGIT;
    localparam int CNTW = (ND > 1) ? $clog2(ND) : 1;
    localparam logic [CNTW-1:0] LAST = CNTW'(ND - 1);

    state_t           state, state_nx;
    logic [WIDTH-1:0] q_sh;
    logic [WIDTH-1:0] x_sh;
    logic [RW-1:0]    carry;
    logic [CNTW-1:0]  cnt;
    logic [DIGIT-1:0] digit_sum;
    logic [RW-1:0]    carry_nx;
    logic             accept;

    div23_digit_mac #(
        .DIGIT   (DIGIT),
        .DIVISOR (DIVISOR),
        .CW      (RW)
    ) u_mac (
        .digit     (q_sh[DIGIT-1:0]),
        .carry_in  (carry),
        .sum       (digit_sum),
        .carry_out (carry_nx)
    );

    assign accept = (state == IDLE) && in_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_sh  <= '0;
            x_sh  <= '0;
            carry <= '0;
            cnt   <= '0;
        end else if (accept) begin
            q_sh  <= q_in;
            carry <= r_in;
            cnt   <= '0;
        end else if (state == RUN) begin
            // New digits enter at the top; after ND shifts the first digit
            // has reached bit 0, giving LSB-first assembly.
            x_sh  <= {digit_sum, x_sh[WIDTH-1:DIGIT]};
            carry <= carry_nx;
            q_sh  <= q_sh >> DIGIT;
            cnt   <= cnt + 1'b1;
        end
    end

`ifdef DIV23_RECON_RANGE_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= (32'(r_in) >= 32'(DIVISOR));
        end
    end

    assign err = (state == DONE) && err_q;
`else
    assign err = 1'b0;
`endif

    // Result outputs are held at zero outside DONE so a reset or a fresh
    // operation never exposes a partially shifted value.
    assign x_out = (state == DONE) ? x_sh : '0;
    assign ovf   = (state == DONE) && (carry != '0);

endmodule

// File: tb/tb_div23_recon.sv
// tb/tb_div23_recon.sv - randomized self-checking bench for div23_recon
module tb_div23_recon;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] q_in = '0;
    logic [4:0]  r_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] x_out;
    logic        ovf;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div23_recon dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q_in      (q_in),
        .r_in      (r_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .ovf       (ovf),
        .err       (err)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the dividend is plain arithmetic on a wide integer.
    function automatic logic [127:0] model(input logic [63:0] q, input logic [4:0] r);
        return {64'd0, q} * 128'd23 + {123'd0, r};
    endfunction

    function automatic logic model_err(input logic [4:0] r);
`ifdef DIV23_RECON_RANGE_CHECK_EN
        return r >= 5'd23;
`else
        return 1'b0;
`endif
    endfunction

    // Called just after a rising edge with the DUT in IDLE.
    task automatic run_pair(input logic [63:0] q, input logic [4:0] r, input int stall);
        logic [127:0] full;
        logic [63:0]  held;
        int           lat;
        full = model(q, r);
        check("in_ready_idle", in_ready, 1'b1);
        in_valid = 1'b1;
        q_in     = q;
        r_in     = r;
        tick();
        // in_valid stays high through the run to prove it is ignored
        q_in = ~q;
        lat  = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("latency", lat, 16);
        check("x_out", x_out, full[63:0]);
        check("ovf", ovf, full[127:64] != 0);
        check("err", err, model_err(r));
        held = x_out;
        for (int i = 0; i < stall; i++) begin
            tick();
            check("stall_valid", out_valid, 1'b1);
            check("stall_x", x_out, held);
            check("stall_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("back_idle", in_ready, 1'b1);
        check("valid_drop", out_valid, 1'b0);
    endtask

    initial begin
        logic [63:0] qr;
        logic [4:0]  rr;
        int          st;

        repeat (2) tick();
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_x_out", x_out, 64'd0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_err", err, 1'b0);
        rst = 1'b0;
        tick();

        run_pair(64'd0, 5'd0, 0);
        run_pair(64'd1, 5'd5, 0);
        run_pair(64'h0B21642C8590B216, 5'd5, 0);
        run_pair(64'h0B21642C8590B216, 5'd6, 0);
        run_pair(64'hFFFFFFFFFFFFFFFF, 5'd22, 0);
        run_pair(64'h1234_5678_9ABC_DEF0, 5'd7, 10);

        // Reset at RUN digit 7
        in_valid = 1'b1;
        q_in     = 64'hDEAD_BEEF_0BAD_F00D;
        r_in     = 5'd9;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        #1;
        check("mid_rst_ready", in_ready, 1'b1);
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_x", x_out, 64'd0);
        check("mid_rst_ovf", ovf, 1'b0);
        check("mid_rst_err", err, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        run_pair(64'd3, 5'd2, 0);

`ifdef DIV23_RECON_RANGE_CHECK_EN
        run_pair(64'd0, 5'd23, 0);
        run_pair(64'd0, 5'd31, 1);
        run_pair(64'd4, 5'd0, 0);
`endif

        for (int n = 0; n < 24; n++) begin
            qr = {$urandom, $urandom};
            if (n % 4 == 0) qr = 64'h0B21642C8590B216 + 64'($urandom_range(0, 3)) - 64'd1;
            if (n % 4 == 1) qr = qr >> $urandom_range(0, 63);
            rr = 5'($urandom_range(0, 22));
            st = $urandom_range(0, 3);
            run_pair(qr, rr, st);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
